// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_reader_pkg;

  localparam int unsigned STATUS_WIDTH_C = 16;

  typedef enum logic [0:0] {
    IDLE_E,
    BURST_E
  } burst_state_t;

endpackage

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// One-entry valid/ready output register carrying a data word and its last flag.
module stream_out_reg #(
  parameter int unsigned DATA_WIDTH_P = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [DATA_WIDTH_P-1:0] data_i,
  input  logic                    last_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH_P-1:0] data_o,
  output logic                    last_o,
  output logic                    can_accept_c_o
);

  logic                    valid_q, valid_d;
  logic [DATA_WIDTH_P-1:0] data_q, data_d;
  logic                    last_q, last_d;

  // Slot is free when empty or when the current word leaves this cycle.
  assign can_accept_c_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO into valid/ready bursts; full bursts
// start on fill level, partial bursts are flushed after an idle timeout.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P    = 8,
  parameter int unsigned ADDR_WIDTH_P    = 4,
  parameter int unsigned TIMEOUT_WIDTH_P = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       fifo_egr_enable,
  input  logic [DATA_WIDTH_P-1:0]    fifo_egr_data,
  input  logic                       fifo_egr_empty,
  input  logic [ADDR_WIDTH_P:0]      fifo_fill_level,
  output logic                       mst_valid,
  input  logic                       mst_ready,
  output logic [DATA_WIDTH_P-1:0]    mst_data,
  output logic                       mst_last,
  input  logic                       cr_enable,
  input  logic [ADDR_WIDTH_P:0]      cr_burst_length,
  input  logic [TIMEOUT_WIDTH_P-1:0] cr_timeout_cycles,
  output logic [STATUS_WIDTH_C-1:0]  sr_burst_count,
  output logic [STATUS_WIDTH_C-1:0]  sr_flush_count
);

  localparam int unsigned LEN_W = ADDR_WIDTH_P + 1;

  burst_state_t               state_q, state_d;
  logic [LEN_W-1:0]           words_left_q, words_left_d;
  logic                       flush_q, flush_d;
  logic [TIMEOUT_WIDTH_P-1:0] timer_q, timer_d;
  logic [STATUS_WIDTH_C-1:0]  burst_cnt_q, burst_cnt_d;
  logic [STATUS_WIDTH_C-1:0]  flush_cnt_q, flush_cnt_d;

  logic [LEN_W-1:0] eff_len;
  logic             pop;
  logic             can_accept;
  logic             out_valid;
  logic             out_last;
  logic             xfer_last;

  assign eff_len   = (cr_burst_length == '0) ? LEN_W'(1) : cr_burst_length;
  assign xfer_last = out_valid && mst_ready && out_last;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    flush_d      = flush_q;
    timer_d      = timer_q;
    burst_cnt_d  = burst_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pop          = 1'b0;

    case (state_q)
      IDLE_E: begin
        if (cr_enable && (fifo_fill_level >= eff_len)) begin
          state_d      = BURST_E;
          words_left_d = eff_len;
          flush_d      = 1'b0;
          timer_d      = '0;
        end else if (cr_enable && (cr_timeout_cycles != '0) && (fifo_fill_level != '0)) begin
          if (timer_q == cr_timeout_cycles) begin
            state_d      = BURST_E;
            words_left_d = fifo_fill_level;
            flush_d      = 1'b1;
            timer_d      = '0;
          end else begin
            timer_d = timer_q + TIMEOUT_WIDTH_P'(1);
          end
        end else begin
          timer_d = '0;
        end
      end

      BURST_E: begin
        pop = (words_left_q != '0) && !fifo_egr_empty && can_accept;
        if (pop) begin
          words_left_d = words_left_q - LEN_W'(1);
        end
        // words_left is already 0 here, so no pop can coincide with the last transfer.
        if (xfer_last) begin
          state_d     = IDLE_E;
          timer_d     = '0;
          burst_cnt_d = burst_cnt_q + STATUS_WIDTH_C'(1);
          if (flush_q) begin
            flush_cnt_d = flush_cnt_q + STATUS_WIDTH_C'(1);
          end
        end
      end

      default: state_d = IDLE_E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE_E;
      words_left_q <= '0;
      flush_q      <= 1'b0;
      timer_q      <= '0;
      burst_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      flush_q      <= flush_d;
      timer_q      <= timer_d;
      burst_cnt_q  <= burst_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  stream_out_reg #(
    .DATA_WIDTH_P(DATA_WIDTH_P)
  ) u_out_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (pop),
    .data_i        (fifo_egr_data),
    .last_i        (words_left_q == LEN_W'(1)),
    .ready_i       (mst_ready),
    .valid_o       (out_valid),
    .data_o        (mst_data),
    .last_o        (out_last),
    .can_accept_c_o(can_accept)
  );

  assign fifo_egr_enable = pop;
  assign mst_valid       = out_valid;
  assign mst_last        = out_last;
  assign sr_burst_count  = burst_cnt_q;
  assign sr_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a behavioural FWFT FIFO and
// an output scoreboard.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_egr_enable;
  logic [DW-1:0] fifo_egr_data;
  logic          fifo_egr_empty;
  logic [LW-1:0] fifo_fill_level;
  logic          mst_valid;
  logic          mst_ready;
  logic [DW-1:0] mst_data;
  logic          mst_last;
  logic          cr_enable;
  logic [LW-1:0] cr_burst_length;
  logic [TW-1:0] cr_timeout_cycles;
  logic [15:0]   sr_burst_count;
  logic [15:0]   sr_flush_count;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH_P   (DW),
    .ADDR_WIDTH_P   (AW),
    .TIMEOUT_WIDTH_P(TW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_egr_enable  (fifo_egr_enable),
    .fifo_egr_data    (fifo_egr_data),
    .fifo_egr_empty   (fifo_egr_empty),
    .fifo_fill_level  (fifo_fill_level),
    .mst_valid        (mst_valid),
    .mst_ready        (mst_ready),
    .mst_data         (mst_data),
    .mst_last         (mst_last),
    .cr_enable        (cr_enable),
    .cr_burst_length  (cr_burst_length),
    .cr_timeout_cycles(cr_timeout_cycles),
    .sr_burst_count   (sr_burst_count),
    .sr_flush_count   (sr_flush_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } sb_t;

  typedef struct {
    int len;
    int tmo;
    int nwords;
    bit stall;
    int exp_words;
    int exp_bursts;
    int exp_flushes;
  } case_t;

  sb_t           sb[$];
  logic [DW-1:0] fq[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            pops = 0;
  int            last_cyc = 0;
  int            first_valid = -1;
  bit            pop_pending = 1'b0;
  bit            stall_prev = 1'b0;
  bit            await_gap = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_egr_empty  = (fq.size() == 0);
    fifo_egr_data   = (fq.size() != 0) ? fq[0] : '0;
    fifo_fill_level = LW'(fq.size());
  endtask

  // One clock: check outputs at the falling edge, then update the FIFO model after the rising edge.
  task automatic cycle(input bit stall);
    sb_t e;
    @(negedge clk);
    cyc++;
    if (fifo_egr_enable) chk("pop_while_empty", 32'(fifo_egr_empty), 32'd0);
    if (stall_prev) begin
      chk("stall_valid", 32'(mst_valid), 32'd1);
      chk("stall_data", 32'(mst_data), 32'(prev_data));
      chk("stall_last", 32'(mst_last), 32'(prev_last));
    end
    if (mst_valid && first_valid < 0) first_valid = cyc;
    if (mst_valid && await_gap) begin
      chk("burst_gap", 32'((cyc - last_cyc) >= 3), 32'd1);
      await_gap = 1'b0;
    end
    if (mst_valid && mst_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_word: got %0h expected no transfer (cycle %0d)", mst_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("word_data", 32'(mst_data), 32'(e.data));
        chk("word_last", 32'(mst_last), 32'(e.last));
      end
      if (mst_last) begin
        await_gap = 1'b1;
        last_cyc  = cyc;
      end
    end
    stall_prev  = mst_valid && !mst_ready;
    prev_data   = mst_data;
    prev_last   = mst_last;
    pop_pending = fifo_egr_enable;
    if (pop_pending) pops++;
    @(posedge clk);
    #1;
    if (pop_pending && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
    mst_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  endtask

  task automatic reset_dut();
    rst_n             = 1'b0;
    cr_enable         = 1'b0;
    cr_burst_length   = '0;
    cr_timeout_cycles = '0;
    mst_ready         = 1'b1;
    fq.delete();
    sb.delete();
    drive_fifo();
    stall_prev  = 1'b0;
    await_gap   = 1'b0;
    pop_pending = 1'b0;
    pops        = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(mst_valid), 32'd0);
    chk("reset_last", 32'(mst_last), 32'd0);
    chk("reset_bursts", 32'(sr_burst_count), 32'd0);
    chk("reset_flushes", 32'(sr_flush_count), 32'd0);
    chk("reset_pop", 32'(fifo_egr_enable), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Fill the FIFO model, program the block and push the words expected to leave it.
  task automatic preload(input int n, input int len, input int tmo, input int nexp, input bit last_at_end);
    logic [DW-1:0] d;
    int            eff;
    sb_t           e;
    eff = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      fq.push_back(d);
    end
    for (int i = 0; i < nexp; i++) begin
      e.data = fq[i];
      e.last = (((i + 1) % eff) == 0) || ((i == nexp - 1) && (tmo != 0 || last_at_end));
      sb.push_back(e);
    end
    cr_burst_length   = LW'(len);
    cr_timeout_cycles = TW'(tmo);
    drive_fifo();
    cr_enable = 1'b1;
  endtask

  task automatic drain(input bit stall);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      cycle(stall);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", sb.size());
    end
    repeat (30) cycle(stall);
  endtask

  initial begin
    case_t cases[6];
    int    start;
    int    n;
    int    r;
    sb_t   e;

    cases[0] = '{len: 4, tmo: 0,  nwords: 8, stall: 1'b0, exp_words: 8, exp_bursts: 2, exp_flushes: 0};
    cases[1] = '{len: 8, tmo: 10, nwords: 3, stall: 1'b0, exp_words: 3, exp_bursts: 1, exp_flushes: 1};
    cases[2] = '{len: 8, tmo: 0,  nwords: 3, stall: 1'b0, exp_words: 0, exp_bursts: 0, exp_flushes: 0};
    cases[3] = '{len: 4, tmo: 0,  nwords: 4, stall: 1'b1, exp_words: 4, exp_bursts: 1, exp_flushes: 0};
    cases[4] = '{len: 0, tmo: 0,  nwords: 2, stall: 1'b0, exp_words: 2, exp_bursts: 2, exp_flushes: 0};
    cases[5] = '{len: 3, tmo: 5,  nwords: 5, stall: 1'b0, exp_words: 5, exp_bursts: 2, exp_flushes: 1};

    for (int c = 0; c < 6; c++) begin
      reset_dut();
      preload(cases[c].nwords, cases[c].len, cases[c].tmo, cases[c].exp_words, 1'b0);
      start       = cyc;
      first_valid = -1;
      mst_ready   = 1'b1;
      drain(cases[c].stall);
      chk("burst_count", 32'(sr_burst_count), 32'(cases[c].exp_bursts));
      chk("flush_count", 32'(sr_flush_count), 32'(cases[c].exp_flushes));
      chk("pop_count", 32'(pops), 32'(cases[c].exp_words));
      chk("fifo_left", 32'(fq.size()), 32'(cases[c].nwords - cases[c].exp_words));
      if (cases[c].tmo != 0 && cases[c].nwords < cases[c].len)
        chk("flush_not_early", 32'((first_valid - start) >= cases[c].tmo), 32'd1);
    end

    // Reset while word 2 of a 4-word burst is on the output.
    reset_dut();
    preload(4, 4, 0, 4, 1'b0);
    n = 0;
    while (!(mst_valid && sb.size() == 3) && n < 50) begin
      cycle(1'b0);
      n++;
    end
    chk("rst_mid_reached", 32'(mst_valid && sb.size() == 3), 32'd1);
    rst_n = 1'b0;
    cycle(1'b0);
    rst_n      = 1'b1;
    stall_prev = 1'b0;
    await_gap  = 1'b0;
    sb.delete();
    chk("rst_mid_valid", 32'(mst_valid), 32'd0);
    chk("rst_mid_bursts", 32'(sr_burst_count), 32'd0);
    chk("rst_mid_flushes", 32'(sr_flush_count), 32'd0);
    chk("rst_mid_idle", 32'(fifo_egr_enable), 32'd0);
    r = fq.size();
    cr_burst_length = LW'((r == 0) ? 1 : r);
    for (int i = 0; i < r; i++) begin
      e.data = fq[i];
      e.last = (i == r - 1);
      sb.push_back(e);
    end
    pops = 0;
    drain(1'b0);
    chk("rst_rec_bursts", 32'(sr_burst_count), 32'((r == 0) ? 0 : 1));
    chk("rst_rec_pops", 32'(pops), 32'(r));
    chk("rst_rec_fifo_left", 32'(fq.size()), 32'd0);

    // Burst length changed mid-burst only affects the following burst.
    reset_dut();
    preload(6, 4, 0, 6, 1'b1);
    n = 0;
    while (sb.size() == 6 && n < 50) begin
      cycle(1'b0);
      n++;
    end
    cr_burst_length = LW'(2);
    drain(1'b0);
    chk("lenchg_bursts", 32'(sr_burst_count), 32'd2);
    chk("lenchg_flushes", 32'(sr_flush_count), 32'd0);
    chk("lenchg_fifo_left", 32'(fq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
